ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 8-bit words; address width fixed at 8.
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low; clears state when 0.
REQ-004 addr_ram  input  8  word address from the CPU (MAR or PC source).
REQ-005 wram  input  1  CPU write strobe, active-low.
REQ-006 rram  input  1  CPU read strobe, active-low.
REQ-007 dataram  inout  8  shared CPU data bus; driven only as REQ-014 states, else 8'bz.
REQ-008 ld_start  input  1  one-cycle pulse requesting a preload burst.
REQ-009 ld_base  input  8  first address of the burst, sampled with ld_start.
REQ-010 ld_valid  input  1  ld_data holds a word to store.
REQ-011 ld_last  input  1  qualifies the final word of a burst; meaningful only with ld_valid.
REQ-012 ld_data  input  8  preload word.
REQ-013 ld_ready  output  1  responder accepts a word this cycle; busy  output  1  CPU must be held (run=0) while 1.

Function
REQ-014 Read: in SERVE with rram=0 and wram=1, dataram SHALL combinationally carry mem[addr_ram] in the same cycle, so the CPU MDR captures it at the next posedge (zero-cycle latency).
REQ-015 Write: in SERVE with wram=0, mem[addr_ram] SHALL take dataram at posedge clk; dataram is not driven.
REQ-016 wram=0 and rram=0 together: write wins; no drive, no bus contention.
REQ-017 States: CLEAR, SERVE, LOAD; reset enters CLEAR.
REQ-018 CLEAR: clr_ptr steps 0..DEPTH-1, writing 0 to one word per cycle; after word DEPTH-1 go to SERVE; DEPTH cycles total; busy=1, ld_ready=0, CPU strobes ignored.
REQ-019 SERVE: busy=0, ld_ready=0; ld_start moves to LOAD next cycle, loading ld_ptr<=ld_base; a CPU write in that same cycle still completes.
REQ-020 LOAD: busy=1, ld_ready=1; each cycle with ld_valid=1 writes ld_data to mem[ld_ptr], ld_ptr increments modulo 256 (255 wraps to 0).
REQ-021 LOAD: ld_valid=1 with ld_last=1 writes that word and returns to SERVE next cycle; ld_valid=0 stalls with no write.
REQ-022 LOAD: CPU strobes ignored (writes discarded, bus not driven); ld_start ignored.
REQ-023 ld_start during CLEAR is ignored (not queued).
REQ-024 Outside SERVE, reads never drive dataram.

Reset
REQ-025 rst=0 at any time, including mid-CLEAR or mid-LOAD, asynchronously forces CLEAR, clr_ptr=0, ld_ptr=0, busy=1, ld_ready=0, dataram=z; an unfinished burst is abandoned.
REQ-026 Memory contents are not reset directly; CLEAR zeroes them after reset release.

Structure
REQ-027 Shared package: state encoding (CLEAR/SERVE/LOAD), DEPTH default, ADDR_W=8, DATA_W=8.
REQ-028 One sub-module, ram_store: DEPTH x 8 array with one synchronous write port and one asynchronous read port; write-port mux (clear/load/CPU) and tri-state driver stay in ram_responder.

Verification
REQ-029 Release reset, wait -> busy=1 for exactly 256 cycles, then 0; reads of addresses 0x00, 0x7F, 0xFF return 0x00.
REQ-030 SERVE: wram=0, addr=0x24, data 0x5A; then rram=0, addr=0x24 -> dataram=0x5A in the same cycle; rram=wram=1 -> dataram=z.
REQ-031 ld_start, ld_base=0xFE, words 0x11,0x22,0x33 (last on 0x33), with one ld_valid=0 gap -> mem[FE]=11, mem[FF]=22, mem[00]=33; busy drops the cycle after the last word.
REQ-032 During LOAD, CPU wram=0 to 0x10 with 0x99 and rram=0 -> mem[10] unchanged, dataram=z.
REQ-033 wram=0 and rram=0 together at 0x30 with 0x77 -> mem[30]=77, responder never drives dataram.
REQ-034 Assert rst=0 after 2 words of a burst -> busy=1 and dataram=z immediately; CLEAR runs 256 cycles; all words read 0x00.

Source files
------------

// File: rtl/ram_responder_pkg.sv
// Shared types and sizes for the RAM responder: FSM state encoding and write-port payload.
package ram_responder_pkg;

  localparam int unsigned DEPTH_DEF = 256;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 8;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_SERVE = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_port_t;

endpackage

// File: rtl/ram_store.sv
// DEPTH x 8 storage: one synchronous write port, one asynchronous read port.
module ram_store
  import ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  wr_port_t          wr,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata_c
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  // Addresses beyond DEPTH are dropped on write and read back as zero.
  always_ff @(posedge clk) begin
    if (wr.we && (32'(wr.addr) < DEPTH)) begin
      mem[IDX_W'(wr.addr)] <= wr.data;
    end
  end

  assign rdata_c = (32'(raddr) < DEPTH) ? mem[IDX_W'(raddr)] : '0;

endmodule

// File: rtl/ram_responder.sv
// CPU-facing RAM with power-up clear and a streaming preload port that holds the CPU off while busy.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_ram,
  input  logic              wram,
  input  logic              rram,
  inout  wire  [DATA_W-1:0] dataram,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic              ld_last,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
  wr_port_t          wr_c;
  logic              drive_c;
  logic [DATA_W-1:0] rdata_c;

  // State, pointers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      ld_ptr_q  <= '0;
      busy      <= 1'b1;
      ld_ready  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ld_ptr_q  <= ld_ptr_d;
      busy      <= (state_d != ST_SERVE);
      ld_ready  <= (state_d == ST_LOAD);
    end
  end

  // Next state plus the single write-port mux (clear / CPU / preload).
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ld_ptr_d  = ld_ptr_q;
    wr_c      = '0;
    drive_c   = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        wr_c.we   = 1'b1;
        wr_c.addr = clr_ptr_q;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == CLR_LAST) begin
          state_d   = ST_SERVE;
          clr_ptr_d = '0;
        end
      end
      ST_SERVE: begin
        wr_c.we   = !wram;
        wr_c.addr = addr_ram;
        wr_c.data = dataram;
        // A simultaneous write strobe takes priority; never drive then.
        drive_c   = !rram && wram;
        if (ld_start) begin
          state_d  = ST_LOAD;
          ld_ptr_d = ld_base;
        end
      end
      ST_LOAD: begin
        wr_c.we   = ld_valid;
        wr_c.addr = ld_ptr_q;
        wr_c.data = ld_data;
        if (ld_valid) begin
          ld_ptr_d = ld_ptr_q + ADDR_W'(1);
          if (ld_last) begin
            state_d = ST_SERVE;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  ram_store #(
    .DEPTH(DEPTH)
  ) u_store (
    .clk    (clk),
    .wr     (wr_c),
    .raddr  (addr_ram),
    .rdata_c(rdata_c)
  );

  assign dataram = drive_c ? rdata_c : 'z;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: clear, CPU read/write, preload bursts and reset mid-burst.
module tb_ram_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr_ram;
  logic       wram;
  logic       rram;
  wire  [7:0] dataram;
  logic       ld_start;
  logic [7:0] ld_base;
  logic       ld_valid;
  logic       ld_last;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       busy;

  logic [7:0] tb_data;
  logic       tb_oe;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  // An undriven bus reads back as 8'hFF through the pull-ups.
  assign dataram = tb_oe ? tb_data : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (dataram[i]);
  end

  always #5 clk = ~clk;

  ram_responder dut (
    .clk     (clk),
    .rst     (rst),
    .addr_ram(addr_ram),
    .wram    (wram),
    .rram    (rram),
    .dataram (dataram),
    .ld_start(ld_start),
    .ld_base (ld_base),
    .ld_valid(ld_valid),
    .ld_last (ld_last),
    .ld_data (ld_data),
    .ld_ready(ld_ready),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string tag);
    @(negedge clk);
    addr_ram = a;
    rram     = 1'b0;
    #1;
    chk(tag, 16'(dataram), 16'(e));
    rram = 1'b1;
  endtask

  task automatic wr_cpu(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr_ram = a;
    tb_data  = d;
    tb_oe    = 1'b1;
    wram     = 1'b0;
    @(negedge clk);
    wram  = 1'b1;
    tb_oe = 1'b0;
  endtask

  initial begin
    rst = 1'b0; addr_ram = '0; wram = 1'b1; rram = 1'b1;
    ld_start = 1'b0; ld_base = '0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    tb_data = '0; tb_oe = 1'b0;

    repeat (3) @(negedge clk);
    addr_ram = 8'h24; rram = 1'b0;
    #1;
    chk("rst_busy", 16'(busy), 16'h1);
    chk("rst_ld_ready", 16'(ld_ready), 16'h0);
    chk("rst_bus_float", 16'(dataram), 16'hFF);
    rram = 1'b1;

    // Power-up clear; a preload request and a CPU write arrive mid-clear and must be ignored.
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      ld_start = (n == 10);
      ld_base  = 8'h33;
      wram     = (n != 20);
      tb_oe    = (n == 20);
      addr_ram = 8'h05;
      tb_data  = 8'hEE;
      n++;
      @(negedge clk);
    end
    ld_start = 1'b0; wram = 1'b1; tb_oe = 1'b0;
    chk("clear_cycles", 16'(n), 16'd256);
    #1;
    chk("serve_busy", 16'(busy), 16'h0);
    chk("serve_ld_ready", 16'(ld_ready), 16'h0);
    rd(8'h00, 8'h00, "clear_00");
    rd(8'h7F, 8'h00, "clear_7f");
    rd(8'hFF, 8'h00, "clear_ff");
    rd(8'h05, 8'h00, "clear_cpu_wr_ignored");

    wr_cpu(8'h24, 8'h5A);
    rd(8'h24, 8'h5A, "serve_rd_24");
    @(negedge clk);
    addr_ram = 8'h24;
    #1;
    chk("idle_float", 16'(dataram), 16'hFF);

    // Both strobes low: first with nobody driving (must float), then with 0x77.
    @(negedge clk);
    addr_ram = 8'h30; wram = 1'b0; rram = 1'b0; tb_oe = 1'b0;
    #1;
    chk("both_low_float", 16'(dataram), 16'hFF);
    @(negedge clk);
    tb_data = 8'h77; tb_oe = 1'b1;
    #1;
    chk("both_low_bus", 16'(dataram), 16'h77);
    @(negedge clk);
    wram = 1'b1; rram = 1'b1; tb_oe = 1'b0;
    rd(8'h30, 8'h77, "both_low_mem");

    // Burst at 0xFE with a gap; a CPU write in the ld_start cycle still lands.
    @(negedge clk);
    ld_start = 1'b1; ld_base = 8'hFE;
    addr_ram = 8'h40; tb_data = 8'h66; tb_oe = 1'b1; wram = 1'b0;
    @(negedge clk);
    ld_start = 1'b0; wram = 1'b1; tb_oe = 1'b0;
    #1;
    chk("load_busy", 16'(busy), 16'h1);
    chk("load_ld_ready", 16'(ld_ready), 16'h1);
    ld_valid = 1'b1; ld_data = 8'h11;
    @(negedge clk);
    ld_data = 8'h22;
    addr_ram = 8'h10; tb_data = 8'h99; tb_oe = 1'b1; wram = 1'b0;
    @(negedge clk);
    ld_valid = 1'b0; wram = 1'b1; tb_oe = 1'b0; rram = 1'b0;
    #1;
    chk("load_rd_float", 16'(dataram), 16'hFF);
    @(negedge clk);
    rram = 1'b1; ld_valid = 1'b1; ld_data = 8'h33; ld_last = 1'b1;
    #1;
    chk("last_word_busy", 16'(busy), 16'h1);
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
    #1;
    chk("after_last_busy", 16'(busy), 16'h0);
    chk("after_last_ld_ready", 16'(ld_ready), 16'h0);
    rd(8'hFE, 8'h11, "load_fe");
    rd(8'hFF, 8'h22, "load_ff");
    rd(8'h00, 8'h33, "load_00_wrap");
    rd(8'h01, 8'h00, "load_gap_no_write");
    rd(8'h10, 8'h00, "load_cpu_wr_ignored");
    rd(8'h40, 8'h66, "start_cycle_cpu_wr");

    // Reset after two words of a burst.
    @(negedge clk);
    ld_start = 1'b1; ld_base = 8'h50;
    @(negedge clk);
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 8'hAA;
    @(negedge clk);
    ld_data = 8'hBB;
    @(negedge clk);
    ld_data = 8'hCC;
    #1;
    chk("pre_rst_ld_ready", 16'(ld_ready), 16'h1);
    rst = 1'b0; addr_ram = 8'h24; rram = 1'b0;
    #1;
    chk("midrst_busy", 16'(busy), 16'h1);
    chk("midrst_ld_ready", 16'(ld_ready), 16'h0);
    chk("midrst_float", 16'(dataram), 16'hFF);
    ld_valid = 1'b0; rram = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("clear2_cycles", 16'(n), 16'd256);
    for (int a = 0; a < 256; a++) begin
      rd(8'(a), 8'h00, $sformatf("clear2_word_%02h", a));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
